// File: rtl/fifo_read_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_read_ctrl_if
// Brief    : FIFO read-port, byte-stream and control/status bundle for
//            fifo_read_ctrl. The master modport is the controller's view.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_read_ctrl_if #(
  parameter int DW = 8,
  parameter int CW = 16
);
  logic [DW-1:0] fifo_data;
  logic          fifo_empty;
  logic          fifo_threshold;
  logic          fifo_underflow;
  logic          fifo_rd;
  logic          burst_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          cnt_clr;
  logic [CW-1:0] pop_count;
  logic          busy;
  logic          err;

  modport master (
    input  fifo_data, fifo_empty, fifo_threshold, fifo_underflow,
    input  burst_en, m_ready, cnt_clr,
    output fifo_rd, m_data, m_valid, pop_count, busy, err
  );

  modport slave (
    output fifo_data, fifo_empty, fifo_threshold, fifo_underflow,
    output burst_en, m_ready, cnt_clr,
    input  fifo_rd, m_data, m_valid, pop_count, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/fifo_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_read_ctrl
// Brief    : Drains a show-ahead FIFO into a 2-entry buffer feeding a
//            valid/ready byte stream; immediate or threshold-burst drain,
//            wrapping pop counter. Macro FIFO_RD_ERR_CHK_EN enables err.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_read_ctrl #(
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  wire              clk,
  input  wire              rst_n,
  fifo_read_ctrl_if.master bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [DW-1:0] buf_q [2];
  logic [DW-1:0] buf_d [2];
  logic          head_q, head_d;
  logic          tail_q, tail_d;
  logic [1:0]    occ_q, occ_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          push;
  logic          xfer;

  // Pop decision looks only at buffer occupancy, never at m_ready.
  assign push = (state_q == DRAIN) && !bus.fifo_empty && (occ_q < 2'd2);
  assign xfer = (occ_q != 2'd0) && bus.m_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!bus.fifo_empty && (!bus.burst_en || bus.fifo_threshold)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.fifo_empty) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    buf_d  = buf_q;
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (push) begin
      buf_d[tail_q] = bus.fifo_data;
      tail_d        = ~tail_q;
    end
    if (xfer) begin
      head_d = ~head_q;
    end
    case ({push, xfer})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if (push) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

`ifdef FIFO_RD_ERR_CHK_EN
  logic x_ready;

  always_comb begin
    x_ready = 1'b0;
`ifndef SYNTHESIS
    // An undriven ready while data is offered is a bench/integration bug.
    x_ready = (occ_q != 2'd0) && $isunknown(bus.m_ready);
`endif
    err_d = err_q | bus.fifo_underflow | x_ready;
    if (bus.cnt_clr) begin
      err_d = 1'b0;
    end
  end
`else
  logic unused_underflow;

  assign unused_underflow = bus.fifo_underflow;
  assign err_d            = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      occ_q    <= 2'd0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.fifo_rd   = push;
  assign bus.m_valid   = (occ_q != 2'd0);
  assign bus.m_data    = buf_q[head_q];
  assign bus.pop_count = cnt_q;
  assign bus.busy      = (state_q == DRAIN) || (occ_q != 2'd0);
  assign bus.err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_read_ctrl
// Brief    : Self-checking bench for fifo_read_ctrl with a queue-style FIFO
//            model, a delivery scoreboard and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_read_ctrl;
  localparam int DW = 8;
  localparam int CW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fifo_read_ctrl_if #(.DW(DW), .CW(CW)) bus ();
  fifo_read_ctrl #(.DW(DW), .CW(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Source FIFO model: circular array addressed by free-running counters.
  logic [7:0]  mem [16];
  int unsigned wcnt = 0;
  int unsigned rcnt = 0;
  assign bus.fifo_empty     = (wcnt == rcnt);
  assign bus.fifo_threshold = ((wcnt - rcnt) >= 8);
  assign bus.fifo_data      = mem[rcnt[3:0]];

  int n_checks = 0;
  int n_pass   = 0;

  // Handshakes are sampled mid-cycle and take effect at the next rising edge.
  logic       pend_pop  = 1'b0;
  logic       pend_xfer = 1'b0;
  logic [7:0] pend_byte = 8'h00;
  int         mdl_occ   = 0;
  int         occ_viol  = 0;
  int         valid_viol = 0;
  int         cyc       = 0;
  longint     n_pops    = 0;
  logic [7:0] got_q[$];
  int         pop_cyc_q[$];

  always @(negedge clk) begin
    mdl_occ = mdl_occ + int'(pend_pop) - int'(pend_xfer);
    if (!rst_n) mdl_occ = 0;
    if (mdl_occ > 2 || mdl_occ < 0) occ_viol++;
    if (bus.m_valid !== (mdl_occ != 0)) valid_viol++;
    pend_pop  = bus.fifo_rd;
    pend_xfer = bus.m_valid & bus.m_ready;
    pend_byte = bus.m_data;
  end

  always @(posedge clk) begin
    cyc++;
    if (pend_pop === 1'b1) begin
      rcnt <= rcnt + 1;
      n_pops++;
      pop_cyc_q.push_back(cyc);
    end
    if (pend_xfer === 1'b1) got_q.push_back(pend_byte);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    mem[wcnt[3:0]] = b;
    wcnt = wcnt + 1;
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (bus.busy === 1'b0 && wcnt == rcnt) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    bus.m_ready = 1'b0; bus.burst_en = 1'b0; bus.cnt_clr = 1'b0; bus.fifo_underflow = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    n_checks++; if (bus.fifo_rd !== 1'b0) $display("FAIL reset_fifo_rd got %b want 0", bus.fifo_rd); else n_pass++;
    n_checks++; if (bus.m_valid !== 1'b0) $display("FAIL reset_m_valid got %b want 0", bus.m_valid); else n_pass++;
    n_checks++; if (bus.m_data !== 8'h00) $display("FAIL reset_m_data got %h want 00", bus.m_data); else n_pass++;
    n_checks++; if (bus.pop_count !== 16'h0000) $display("FAIL reset_pop_count got %h want 0000", bus.pop_count); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.err !== 1'b0) $display("FAIL reset_err got %b want 0", bus.err); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_immediate();
    logic [7:0] exp [3];
    int bad;
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
    got_q.delete();
    bus.burst_en = 1'b0; bus.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) write_byte(exp[i]);
    tick();
    n_checks++; if (bus.fifo_rd !== 1'b1) $display("FAIL imm_first_pop got %b want 1", bus.fifo_rd); else n_pass++;
    n_checks++; if (bus.m_valid !== 1'b0) $display("FAIL imm_valid_c1 got %b want 0", bus.m_valid); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== exp[i])
        $display("FAIL imm_byte%0d got v=%b d=%h want v=1 d=%h", i, bus.m_valid, bus.m_data, exp[i]);
      else n_pass++;
    end
    tick();
    n_checks++; if (bus.m_valid !== 1'b0) $display("FAIL imm_valid_end got %b want 0", bus.m_valid); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL imm_busy_end got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.pop_count !== 16'd3) $display("FAIL imm_pop_count got %0d want 3", bus.pop_count); else n_pass++;
    bad = (got_q.size() == 3) ? 0 : 1;
    for (int i = 0; i < 3 && i < got_q.size(); i++) if (got_q[i] !== exp[i]) bad++;
    n_checks++; if (bad != 0) $display("FAIL imm_order got %0d bytes (%0d wrong) want 3 in order", got_q.size(), bad); else n_pass++;
  endtask

  task automatic test_burst();
    longint base;
    int bad;
    bit ok;
    got_q.delete();
    bus.burst_en = 1'b1; bus.m_ready = 1'b1;
    base = n_pops;
    for (int i = 0; i < 7; i++) begin
      write_byte(8'hA0 + 8'(i));
      tick();
    end
    repeat (4) tick();
    n_checks++; if (n_pops != base) $display("FAIL burst_below_thr pops got %0d want 0", n_pops - base); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL burst_below_thr_busy got %b want 0", bus.busy); else n_pass++;
    write_byte(8'hA7);
    wait_idle(40, ok);
    n_checks++; if (!ok) $display("FAIL burst_timeout got busy=%b want idle", bus.busy); else n_pass++;
    n_checks++; if (n_pops - base != 8) $display("FAIL burst_pops got %0d want 8", n_pops - base); else n_pass++;
    n_checks++;
    if (pop_cyc_q.size() < 8 || pop_cyc_q[pop_cyc_q.size()-1] - pop_cyc_q[pop_cyc_q.size()-8] != 7)
      $display("FAIL burst_back_to_back got span %0d want 7",
               pop_cyc_q.size() < 8 ? -1 : pop_cyc_q[pop_cyc_q.size()-1] - pop_cyc_q[pop_cyc_q.size()-8]);
    else n_pass++;
    bad = (got_q.size() == 8) ? 0 : 1;
    for (int i = 0; i < 8 && i < got_q.size(); i++) if (got_q[i] !== 8'hA0 + 8'(i)) bad++;
    n_checks++; if (bad != 0) $display("FAIL burst_order got %0d bytes (%0d wrong) want 8", got_q.size(), bad); else n_pass++;
    n_checks++; if (bus.pop_count !== 16'd11) $display("FAIL burst_pop_count got %0d want 11", bus.pop_count); else n_pass++;
    bus.burst_en = 1'b0;
  endtask

  task automatic test_backpressure();
    longint base;
    int bad;
    int unstable;
    bit seen;
    bit ok;
    got_q.delete();
    bus.burst_en = 1'b0; bus.m_ready = 1'b0;
    base = n_pops; unstable = 0; seen = 1'b0;
    for (int i = 0; i < 5; i++) write_byte(8'h51 + 8'(i));
    for (int i = 0; i < 10; i++) begin
      tick();
      if (seen && bus.m_valid !== 1'b1) unstable++;
      if (bus.m_valid === 1'b1) begin
        seen = 1'b1;
        if (bus.m_data !== 8'h51) unstable++;
      end
    end
    n_checks++; if (n_pops - base != 2) $display("FAIL bp_pops got %0d want 2", n_pops - base); else n_pass++;
    n_checks++; if (bus.fifo_rd !== 1'b0) $display("FAIL bp_rd_low got %b want 0", bus.fifo_rd); else n_pass++;
    n_checks++; if (bus.m_valid !== 1'b1 || unstable != 0) $display("FAIL bp_stable got v=%b glitches=%0d want v=1 glitches=0", bus.m_valid, unstable); else n_pass++;
    bus.m_ready = 1'b1;
    wait_idle(50, ok);
    n_checks++; if (!ok) $display("FAIL bp_timeout got busy=%b want idle", bus.busy); else n_pass++;
    n_checks++; if (n_pops - base != 5) $display("FAIL bp_total_pops got %0d want 5", n_pops - base); else n_pass++;
    bad = (got_q.size() == 5) ? 0 : 1;
    for (int i = 0; i < 5 && i < got_q.size(); i++) if (got_q[i] !== 8'h51 + 8'(i)) bad++;
    n_checks++; if (bad != 0) $display("FAIL bp_order got %0d bytes (%0d wrong) want 5", got_q.size(), bad); else n_pass++;
    n_checks++; if (bus.pop_count !== 16'd16) $display("FAIL bp_pop_count got %0d want 16", bus.pop_count); else n_pass++;
  endtask

  task automatic test_reset_midburst();
    longint base;
    int bad;
    bit ok;
    bus.burst_en = 1'b1; bus.m_ready = 1'b0;
    base = n_pops;
    for (int i = 0; i < 9; i++) write_byte(8'h61 + 8'(i));
    repeat (6) tick();
    n_checks++; if (bus.m_valid !== 1'b1 || n_pops - base != 2) $display("FAIL mid_prefill got v=%b pops=%0d want v=1 pops=2", bus.m_valid, n_pops - base); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.m_valid !== 1'b0) $display("FAIL mid_rst_valid got %b want 0", bus.m_valid); else n_pass++;
    n_checks++; if (bus.m_data !== 8'h00) $display("FAIL mid_rst_data got %h want 00", bus.m_data); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0 || bus.fifo_rd !== 1'b0) $display("FAIL mid_rst_busy_rd got busy=%b rd=%b want 0 0", bus.busy, bus.fifo_rd); else n_pass++;
    n_checks++; if (bus.pop_count !== 16'h0000) $display("FAIL mid_rst_count got %h want 0000", bus.pop_count); else n_pass++;
    got_q.delete();
    bus.burst_en = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.m_ready = 1'b1;
    wait_idle(60, ok);
    n_checks++; if (!ok) $display("FAIL mid_timeout got busy=%b want idle", bus.busy); else n_pass++;
    bad = (got_q.size() == 7) ? 0 : 1;
    for (int i = 0; i < 7 && i < got_q.size(); i++) if (got_q[i] !== 8'h63 + 8'(i)) bad++;
    n_checks++; if (bad != 0) $display("FAIL mid_no_stale got %0d bytes first=%h (%0d wrong) want 7 from 63", got_q.size(), got_q.size() ? got_q[0] : 8'h00, bad); else n_pass++;
    n_checks++; if (bus.pop_count !== 16'd7) $display("FAIL mid_pop_count got %0d want 7", bus.pop_count); else n_pass++;
  endtask

  task automatic test_err();
`ifdef FIFO_RD_ERR_CHK_EN
    n_checks++; if (bus.err !== 1'b0) $display("FAIL err_initial got %b want 0", bus.err); else n_pass++;
    bus.fifo_underflow = 1'b1; tick(); bus.fifo_underflow = 1'b0;
    n_checks++; if (bus.err !== 1'b1) $display("FAIL err_set got %b want 1", bus.err); else n_pass++;
    repeat (4) tick();
    n_checks++; if (bus.err !== 1'b1) $display("FAIL err_sticky got %b want 1", bus.err); else n_pass++;
    bus.cnt_clr = 1'b1; tick(); bus.cnt_clr = 1'b0;
    n_checks++; if (bus.err !== 1'b0) $display("FAIL err_clear got %b want 0", bus.err); else n_pass++;
`else
    bus.fifo_underflow = 1'b1; tick(); bus.fifo_underflow = 1'b0;
    n_checks++; if (bus.err !== 1'b0) $display("FAIL err_tied got %b want 0", bus.err); else n_pass++;
    repeat (3) tick();
    n_checks++; if (bus.err !== 1'b0) $display("FAIL err_tied_later got %b want 0", bus.err); else n_pass++;
`endif
  endtask

  task automatic test_random();
    logic [7:0] sent_q[$];
    logic [7:0] b;
    int bad;
    bit ok;
    bus.cnt_clr = 1'b1; tick(); bus.cnt_clr = 1'b0;
    sent_q.delete(); got_q.delete();
    for (int c = 0; c < 3000; c++) begin
      bus.m_ready = ($urandom_range(0, 3) != 0);
      if (c % 150 == 0) bus.burst_en = 1'($urandom_range(0, 1));
      if ((wcnt - rcnt) < 16 && $urandom_range(0, 2) == 0) begin
        b = 8'($urandom);
        write_byte(b);
        sent_q.push_back(b);
      end
      tick();
    end
    bus.burst_en = 1'b0; bus.m_ready = 1'b1;
    tick();
    wait_idle(100, ok);
    n_checks++; if (!ok) $display("FAIL rnd_timeout got busy=%b want idle", bus.busy); else n_pass++;
    bad = (got_q.size() == sent_q.size()) ? 0 : 1;
    for (int i = 0; i < got_q.size() && i < sent_q.size(); i++) if (got_q[i] !== sent_q[i]) bad++;
    n_checks++; if (bad != 0) $display("FAIL rnd_stream got %0d bytes (%0d wrong) want %0d", got_q.size(), bad, sent_q.size()); else n_pass++;
    n_checks++; if (bus.pop_count !== 16'(sent_q.size())) $display("FAIL rnd_pop_count got %0d want %0d", bus.pop_count, sent_q.size()); else n_pass++;
    n_checks++; if (occ_viol != 0) $display("FAIL rnd_occupancy got %0d overfills want 0", occ_viol); else n_pass++;
    n_checks++; if (valid_viol != 0) $display("FAIL rnd_valid got %0d wrong m_valid cycles want 0", valid_viol); else n_pass++;
  endtask

  task automatic test_counter_wrap();
    int sent;
    int guard;
    bit ok;
    bit found;
    longint base;
    bus.burst_en = 1'b0; bus.m_ready = 1'b1;
    bus.cnt_clr = 1'b1; tick(); bus.cnt_clr = 1'b0;
    n_checks++; if (bus.pop_count !== 16'h0000) $display("FAIL wrap_clear got %h want 0000", bus.pop_count); else n_pass++;
    sent = 0; guard = 0;
    while (sent < 65535 && guard < 80000) begin
      if ((wcnt - rcnt) < 16) begin
        write_byte(8'(sent));
        sent++;
      end
      if (got_q.size() > 1024) got_q.delete();
      if (pop_cyc_q.size() > 1024) pop_cyc_q.delete();
      guard++;
      tick();
    end
    wait_idle(100, ok);
    n_checks++; if (!ok || sent != 65535) $display("FAIL wrap_fill got sent=%0d idle=%b want 65535 1", sent, ok); else n_pass++;
    n_checks++; if (bus.pop_count !== 16'hFFFF) $display("FAIL wrap_all_ones got %h want ffff", bus.pop_count); else n_pass++;
    write_byte(8'h5A);
    wait_idle(20, ok);
    n_checks++; if (bus.pop_count !== 16'h0000) $display("FAIL wrap_rollover got %h want 0000", bus.pop_count); else n_pass++;
    base = n_pops;
    write_byte(8'hC3);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.fifo_rd === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    n_checks++; if (!found) $display("FAIL wrap_pop_seen got rd=%b want 1", bus.fifo_rd); else n_pass++;
    bus.cnt_clr = 1'b1; tick(); bus.cnt_clr = 1'b0;
    n_checks++; if (bus.pop_count !== 16'h0000 || n_pops - base != 1) $display("FAIL clr_priority got cnt=%h pops=%0d want 0000 1", bus.pop_count, n_pops - base); else n_pass++;
    wait_idle(20, ok);
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_burst();
    test_backpressure();
    test_reset_midburst();
    test_err();
    test_random();
    test_counter_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
